// File: rtl/spi_mem_ctrl_fsm.sv
// Transaction sequencer for the SPI data memory: command, address latch,
// read prefetch / write commit strobes and MISO enable, with optional burst.
module spi_mem_ctrl_fsm #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int BURST_EN     = 1,
  localparam int CMD_BITS    = ADDR_WIDTH + 1,
  localparam int MAX_AD      = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH,
  localparam int MAX_ALL     = (MAX_AD > READ_LATENCY) ? MAX_AD : READ_LATENCY,
  localparam int CNT_W       = $clog2(MAX_ALL + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk_posedge,
  input  logic             sclk_negedge,
  input  logic             rw_bit,
  output logic             addr_we,
  output logic             addr_inc,
  output logic             dm_we,
  output logic             sr_we,
  output logic             miso_enable,
  output logic             busy,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_GET          = 3'd1,
    S_GOT          = 3'd2,
    S_READ_WAIT    = 3'd3,
    S_READ_SHIFT   = 3'd4,
    S_WRITE_SHIFT  = 3'd5,
    S_WRITE_COMMIT = 3'd6,
    S_DONE         = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(READ_LATENCY - 1);
  localparam logic             BURST  = (BURST_EN != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic addr_we_q, addr_inc_q, dm_we_q;
  logic sr_we_q, miso_q, busy_q;
  logic addr_inc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cs) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_GET;
          cnt_d   = '0;
        end
        S_GET: begin
          if (sclk_posedge) begin
            if (cnt_q == A_LAST) begin
              state_d = S_GOT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_GOT: begin
          state_d = rw_bit ? S_READ_WAIT : S_WRITE_SHIFT;
          cnt_d   = '0;
        end
        S_READ_WAIT: begin
          if (cnt_q == L_LAST) begin
            state_d = S_READ_SHIFT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_READ_SHIFT: begin
          if (sclk_negedge) begin
            if (cnt_q == D_LAST) begin
              state_d = BURST ? S_READ_WAIT : S_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_WRITE_SHIFT: begin
          if (sclk_posedge) begin
            if (cnt_q == D_LAST) begin
              state_d = S_WRITE_COMMIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_WRITE_COMMIT: begin
          state_d = BURST ? S_WRITE_SHIFT : S_DONE;
          cnt_d   = '0;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    addr_inc_d = 1'b0;
    if (BURST) begin
      addr_inc_d = (state_d == S_WRITE_COMMIT) ||
                   ((state_q == S_READ_SHIFT) &&
                    (state_d == S_READ_WAIT));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_we_q  <= 1'b0;
      addr_inc_q <= 1'b0;
      dm_we_q    <= 1'b0;
      sr_we_q    <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_we_q  <= (state_d == S_GOT);
      addr_inc_q <= addr_inc_d;
      dm_we_q    <= (state_d == S_WRITE_COMMIT);
      sr_we_q    <= (state_d == S_READ_WAIT) && (cnt_d == L_LAST);
      miso_q     <= (state_d == S_READ_SHIFT);
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

  assign addr_we     = addr_we_q;
  assign addr_inc    = addr_inc_q;
  assign dm_we       = dm_we_q;
  assign sr_we       = sr_we_q;
  assign miso_enable = miso_q;
  assign busy        = busy_q;
  assign state       = state_q;
  assign bit_count   = cnt_q;

endmodule

// File: tb/tb_spi_mem_ctrl_fsm.sv
// Directed bench: u0 single-word L=1, u1 burst L=1, u2 burst L=3,
// all driven by the same chip select / strobe stimulus.
module tb_spi_mem_ctrl_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs = 1'b1;
  logic sp = 1'b0;
  logic sn = 1'b0;
  logic rw = 1'b0;

  logic [2:0] addr_we, addr_inc, dm_we, sr_we, miso, busy;
  logic [2:0] st [3];
  logic [3:0] bc [3];

  int checks = 0;
  int errors = 0;
  int n_awe [3];
  int n_inc [3];
  int n_dm [3];
  int n_sr [3];
  int n_miso [3];
  logic [6:0] am;

  always #5 clk = ~clk;

  spi_mem_ctrl_fsm #(
    .ADDR_WIDTH(7), .DATA_WIDTH(8), .READ_LATENCY(1), .BURST_EN(0)
  ) u0 (
    .clk(clk), .reset(reset), .cs(cs),
    .sclk_posedge(sp), .sclk_negedge(sn), .rw_bit(rw),
    .addr_we(addr_we[0]), .addr_inc(addr_inc[0]), .dm_we(dm_we[0]),
    .sr_we(sr_we[0]), .miso_enable(miso[0]), .busy(busy[0]),
    .state(st[0]), .bit_count(bc[0])
  );

  spi_mem_ctrl_fsm #(
    .ADDR_WIDTH(7), .DATA_WIDTH(8), .READ_LATENCY(1), .BURST_EN(1)
  ) u1 (
    .clk(clk), .reset(reset), .cs(cs),
    .sclk_posedge(sp), .sclk_negedge(sn), .rw_bit(rw),
    .addr_we(addr_we[1]), .addr_inc(addr_inc[1]), .dm_we(dm_we[1]),
    .sr_we(sr_we[1]), .miso_enable(miso[1]), .busy(busy[1]),
    .state(st[1]), .bit_count(bc[1])
  );

  spi_mem_ctrl_fsm #(
    .ADDR_WIDTH(7), .DATA_WIDTH(8), .READ_LATENCY(3), .BURST_EN(1)
  ) u2 (
    .clk(clk), .reset(reset), .cs(cs),
    .sclk_posedge(sp), .sclk_negedge(sn), .rw_bit(rw),
    .addr_we(addr_we[2]), .addr_inc(addr_inc[2]), .dm_we(dm_we[2]),
    .sr_we(sr_we[2]), .miso_enable(miso[2]), .busy(busy[2]),
    .state(st[2]), .bit_count(bc[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      n_awe[i] = 0; n_inc[i] = 0; n_dm[i] = 0;
      n_sr[i] = 0; n_miso[i] = 0;
    end
  endtask

  // Advance one clk, sample 1 time unit later, tally strobe cycles.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_awe[i]  += int'(addr_we[i]);
      n_inc[i]  += int'(addr_inc[i]);
      n_dm[i]   += int'(dm_we[i]);
      n_sr[i]   += int'(sr_we[i]);
      n_miso[i] += int'(miso[i]);
    end
    if (addr_we[1]) am = 7'h7F;
    else if (addr_inc[1]) am = am + 7'd1;
  endtask

  task automatic pos(input int n);
    repeat (n) begin
      sp = 1'b1;
      step();
      sp = 1'b0;
    end
  endtask

  task automatic neg(input int n);
    repeat (n) begin
      sn = 1'b1;
      step();
      sn = 1'b0;
    end
  endtask

  initial begin
    am = 7'h00;
    clr();
    step();
    step();
    chk("rst_state", st[0], 0);
    chk("rst_cnt", bc[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_outs", {addr_we, addr_inc, dm_we, sr_we, miso}, 0);
    reset = 1'b0;
    step();

    // single write
    rw = 1'b0; clr(); cs = 1'b0;
    step();
    chk("wr_get", st[0], 1);
    chk("wr_busy", busy[0], 1);
    pos(7);
    chk("wr_cmd_cnt", bc[0], 7);
    chk("wr_cmd_st", st[0], 1);
    pos(1);
    chk("wr_got", st[0], 2);
    chk("wr_awe", addr_we[0], 1);
    step();
    chk("wr_shift", st[0], 5);
    chk("wr_awe_off", addr_we[0], 0);
    pos(8);
    chk("wr_commit", st[0], 6);
    chk("wr_dm_we", dm_we[0], 1);
    chk("wr_noinc", addr_inc[0], 0);
    chk("wr_b_inc", addr_inc[1], 1);
    chk("wr_b_dm", dm_we[1], 1);
    step();
    chk("wr_done", st[0], 7);
    chk("wr_done_busy", busy[0], 0);
    chk("wr_dm_off", dm_we[0], 0);
    chk("wr_b_back", st[1], 5);
    chk("wr_dm_cnt", n_dm[0], 1);
    chk("wr_awe_cnt", n_awe[0], 1);
    cs = 1'b1;
    step();
    chk("wr_idle", st[0], 0);

    // single read on u0, burst read on u1
    rw = 1'b1; clr(); cs = 1'b0;
    step();
    pos(8);
    chk("rd_got", st[0], 2);
    step();
    chk("rd_wait", st[0], 3);
    chk("rd_sr_we", sr_we[0], 1);
    chk("rd_l3_sr0", sr_we[2], 0);
    step();
    chk("rd_shift", st[0], 4);
    chk("rd_miso", miso[0], 1);
    chk("rd_sr_off", sr_we[0], 0);
    neg(7);
    chk("rd_cnt7", bc[0], 7);
    chk("rd_miso7", miso[0], 1);
    neg(1);
    chk("rd_done", st[0], 7);
    chk("rd_miso_off", miso[0], 0);
    chk("rd_busy_off", busy[0], 0);
    chk("rd_miso_cnt", n_miso[0], 8);
    chk("br_wait", st[1], 3);
    chk("br_inc", addr_inc[1], 1);
    chk("br_sr_we", sr_we[1], 1);
    chk("br_wrap", am, 7'h00);
    step();
    chk("br_shift2", st[1], 4);
    chk("br_inc_off", addr_inc[1], 0);
    neg(8);
    chk("br_wait3", st[1], 3);
    step();
    neg(7);
    chk("rd_ignore", st[0], 7);
    cs = 1'b1; sn = 1'b1;
    step();
    sn = 1'b0;
    chk("br_idle", st[1], 0);
    chk("br_sr_cnt", n_sr[1], 3);
    chk("br_inc_cnt", n_inc[1], 2);
    chk("rd_sr_cnt", n_sr[0], 1);
    chk("rd_miso_tot", n_miso[0], 8);

    // latency 3 on u2, then async reset while u0 sits in READ_SHIFT
    rw = 1'b1; clr(); cs = 1'b0;
    step();
    pos(8);
    step();
    chk("l3_w0", st[2], 3);
    chk("l3_sr0", sr_we[2], 0);
    step();
    chk("l3_w1", st[2], 3);
    chk("l3_sr1", sr_we[2], 0);
    step();
    chk("l3_w2", st[2], 3);
    chk("l3_sr2", sr_we[2], 1);
    step();
    chk("l3_shift", st[2], 4);
    chk("l3_sr_off", sr_we[2], 0);
    chk("l3_sr_cnt", n_sr[2], 1);
    chk("ar_pre", st[0], 4);
    #2 reset = 1'b1;
    #1;
    chk("ar_state", st[0], 0);
    chk("ar_miso", miso[0], 0);
    chk("ar_miso2", miso[2], 0);
    step();
    cs = 1'b1;
    reset = 1'b0;
    step();

    // abort mid-write
    rw = 1'b0; clr(); cs = 1'b0;
    step();
    pos(8);
    step();
    pos(5);
    chk("ab_cnt5", bc[0], 5);
    chk("ab_st", st[0], 5);
    cs = 1'b1;
    step();
    chk("ab_idle", st[0], 0);
    chk("ab_cnt0", bc[0], 0);
    chk("ab_dm_cnt", n_dm[0], 0);

    // cs rises on the final data edge: no commit
    clr(); cs = 1'b0;
    step();
    pos(8);
    step();
    pos(7);
    cs = 1'b1; sp = 1'b1;
    step();
    sp = 1'b0;
    step();
    chk("ab8_idle", st[0], 0);
    chk("ab8_dm", n_dm[0] + n_dm[1] + n_dm[2], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
